ysyx_25030093_csr: RTL and testbench

Machine-mode CSR register file and trap sequencer for the ysyx_25030093 single-issue core. It sits directly downstream of the ALU: it supplies `csr_data` to the ALU for CSRRW/CSRRS and commits the ALU's `csr_wdata` result. It also performs the architectural side effects of `ecall` and `mret` and hands a registered redirect PC to the fetch stage.

---
 rtl/ysyx_25030093_csr.sv | 143 ++++++++++++++
 tb/tb_ysyx_25030093_csr.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_csr.sv
// +----------------------------------------------------------------------------+
// | Module  : ysyx_25030093_csr                                                |
// | Brief   : M-mode CSR file and ECALL/MRET trap sequencer; optional 64-bit   |
// |           mcycle counter enabled by YSYX_25030093_CSR_MCYCLE_EN.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module ysyx_25030093_csr #(
  parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_commit,
  input  logic [11:0] csr_addr,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_data,
  output logic        csr_illegal,
  input  logic        ecall,
  input  logic        mret,
  input  logic [31:0] pc,
  output logic        trap_valid,
  output logic [31:0] trap_pc
);

  localparam logic [11:0] c_addr_mstatus   = 12'h300;
  localparam logic [11:0] c_addr_mtvec     = 12'h305;
  localparam logic [11:0] c_addr_mscratch  = 12'h340;
  localparam logic [11:0] c_addr_mepc      = 12'h341;
  localparam logic [11:0] c_addr_mcause    = 12'h342;
  localparam logic [11:0] c_addr_mvendorid = 12'hF11;
  localparam logic [11:0] c_addr_marchid   = 12'hF12;
  localparam logic [11:0] c_addr_mcycle    = 12'hB00;
  localparam logic [11:0] c_addr_mcycleh   = 12'hB80;
  localparam logic [11:0] c_addr_cycle     = 12'hC00;
  localparam logic [11:0] c_addr_cycleh    = 12'hC80;
  localparam logic [31:0] c_mvendorid      = 32'h7973_7978;
  localparam logic [31:0] c_marchid        = 32'h017D_EDCD;

  logic [31:0] r_mstatus;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic        r_trap_valid;
  logic [31:0] r_trap_pc;
  logic [31:0] w_rdata;
  logic        w_illegal;
  logic        w_wr;

  // A CSR write only lands when no trap action claims the commit.
  assign w_wr = inst_commit & csr_wen & ~ecall & ~mret;

`ifdef YSYX_25030093_CSR_MCYCLE_EN
  logic [63:0] r_mcycle;
  logic        w_wr_lo;
  logic        w_wr_hi;

  assign w_wr_lo = w_wr & (csr_addr == c_addr_mcycle);
  assign w_wr_hi = w_wr & (csr_addr == c_addr_mcycleh);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcycle <= 64'd0;
    end else if (w_wr_lo) begin
      r_mcycle[31:0] <= csr_wdata;
    end else if (w_wr_hi) begin
      r_mcycle[63:32] <= csr_wdata;
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end
`endif

  always_comb begin
    w_rdata   = 32'd0;
    w_illegal = 1'b0;
    case (csr_addr)
      c_addr_mstatus:   w_rdata = r_mstatus;
      c_addr_mtvec:     w_rdata = r_mtvec;
      c_addr_mscratch:  w_rdata = r_mscratch;
      c_addr_mepc:      w_rdata = r_mepc;
      c_addr_mcause:    w_rdata = r_mcause;
      c_addr_mvendorid: w_rdata = c_mvendorid;
      c_addr_marchid:   w_rdata = c_marchid;
`ifdef YSYX_25030093_CSR_MCYCLE_EN
      c_addr_mcycle, c_addr_cycle:   w_rdata = r_mcycle[31:0];
      c_addr_mcycleh, c_addr_cycleh: w_rdata = r_mcycle[63:32];
`endif
      default:          w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mstatus    <= MSTATUS_RST;
      r_mtvec      <= MTVEC_RST;
      r_mscratch   <= 32'd0;
      r_mepc       <= 32'd0;
      r_mcause     <= 32'd0;
      r_trap_valid <= 1'b0;
      r_trap_pc    <= 32'd0;
    end else begin
      r_trap_valid <= 1'b0;
      if (inst_commit) begin
        if (ecall) begin
          // MPP=11, MPIE<=MIE, MIE<=0
          r_mepc       <= pc;
          r_mcause     <= 32'd11;
          r_mstatus    <= {r_mstatus[31:13], 2'b11, r_mstatus[10:8], r_mstatus[3],
                           r_mstatus[6:4], 1'b0, r_mstatus[2:0]};
          r_trap_pc    <= {r_mtvec[31:2], 2'b00};
          r_trap_valid <= 1'b1;
        end else if (mret) begin
          // MPP=11, MPIE<=1, MIE<=MPIE
          r_mstatus    <= {r_mstatus[31:13], 2'b11, r_mstatus[10:8], 1'b1,
                           r_mstatus[6:4], r_mstatus[7], r_mstatus[2:0]};
          r_trap_pc    <= r_mepc;
          r_trap_valid <= 1'b1;
        end else if (w_wr) begin
          case (csr_addr)
            c_addr_mstatus:  r_mstatus  <= csr_wdata;
            c_addr_mtvec:    r_mtvec    <= csr_wdata;
            c_addr_mscratch: r_mscratch <= csr_wdata;
            c_addr_mepc:     r_mepc     <= {csr_wdata[31:2], 2'b00};
            c_addr_mcause:   r_mcause   <= csr_wdata;
            default:         ;
          endcase
        end
      end
    end
  end

  assign csr_data    = w_rdata;
  assign csr_illegal = w_illegal;
  assign trap_valid  = r_trap_valid;
  assign trap_pc     = r_trap_pc;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25030093_csr.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_ysyx_25030093_csr                                             |
// | Brief   : Directed plus randomized bench against a behavioural CSR model.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_25030093_csr;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_commit;
  logic [11:0] csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_data;
  logic        csr_illegal;
  logic        ecall;
  logic        mret;
  logic [31:0] pc;
  logic        trap_valid;
  logic [31:0] trap_pc;

  always #5 clk = ~clk;

  ysyx_25030093_csr dut (
    .clk         (clk),
    .reset       (reset),
    .inst_commit (inst_commit),
    .csr_addr    (csr_addr),
    .csr_wen     (csr_wen),
    .csr_wdata   (csr_wdata),
    .csr_data    (csr_data),
    .csr_illegal (csr_illegal),
    .ecall       (ecall),
    .mret        (mret),
    .pc          (pc),
    .trap_valid  (trap_valid),
    .trap_pc     (trap_pc)
  );

`ifdef YSYX_25030093_CSR_MCYCLE_EN
  localparam bit c_has_cycle = 1'b1;
`else
  localparam bit c_has_cycle = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference architectural state
  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause, m_tpc;
  logic [63:0] m_cycle;
  logic        m_tv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mstatus = 32'h0000_1800; m_mtvec = 32'h0; m_mscratch = 32'h0;
    m_mepc = 32'h0; m_mcause = 32'h0; m_cycle = 64'h0; m_tv = 1'b0; m_tpc = 32'h0;
  endfunction

  // {illegal, data}
  function automatic logic [32:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'hF11: return {1'b0, 32'h7973_7978};
      12'hF12: return {1'b0, 32'h017D_EDCD};
      12'hB00, 12'hC00: return c_has_cycle ? {1'b0, m_cycle[31:0]}  : {1'b1, 32'h0};
      12'hB80, 12'hC80: return c_has_cycle ? {1'b0, m_cycle[63:32]} : {1'b1, 32'h0};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic void model_edge(input logic c, input logic w, input logic [11:0] a,
                                     input logic [31:0] d, input logic e, input logic m,
                                     input logic [31:0] p);
    bit cyc_written = 1'b0;
    m_tv = 1'b0;
    if (c && e) begin
      m_tpc = {m_mtvec[31:2], 2'b00};
      m_mepc = p;
      m_mcause = 32'd11;
      m_mstatus[7] = m_mstatus[3];
      m_mstatus[3] = 1'b0;
      m_mstatus[12:11] = 2'b11;
      m_tv = 1'b1;
    end else if (c && m) begin
      m_tpc = m_mepc;
      m_mstatus[3] = m_mstatus[7];
      m_mstatus[7] = 1'b1;
      m_mstatus[12:11] = 2'b11;
      m_tv = 1'b1;
    end else if (c && w) begin
      case (a)
        12'h300: m_mstatus  = d;
        12'h305: m_mtvec    = d;
        12'h340: m_mscratch = d;
        12'h341: m_mepc     = d & 32'hFFFF_FFFC;
        12'h342: m_mcause   = d;
        12'hB00: if (c_has_cycle) begin m_cycle[31:0]  = d; cyc_written = 1'b1; end
        12'hB80: if (c_has_cycle) begin m_cycle[63:32] = d; cyc_written = 1'b1; end
        default: ;
      endcase
    end
    if (!cyc_written) m_cycle = m_cycle + 64'd1;
  endfunction

  // One clock: drive at posedge+1, check reads, take edge, check redirect.
  task automatic step(input logic c, input logic w, input logic [11:0] a, input logic [31:0] d,
                      input logic e, input logic m, input logic [31:0] p);
    logic [32:0] r;
    inst_commit = c; csr_wen = w; csr_addr = a; csr_wdata = d; ecall = e; mret = m; pc = p;
    #1;
    r = model_read(a);
    chk("csr_data", csr_data, r[31:0]);
    chk("csr_illegal", 32'(csr_illegal), 32'(r[32]));
    @(posedge clk);
    model_edge(c, w, a, d, e, m, p);
    #1;
    chk("trap_valid", 32'(trap_valid), 32'(m_tv));
    if (m_tv) chk("trap_pc", trap_pc, m_tpc);
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    inst_commit = 1'b0; csr_wen = 1'b0; ecall = 1'b0; mret = 1'b0; csr_addr = a;
    #1;
    chk(tag, csr_data, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    inst_commit = 1'b0; csr_wen = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    ecall = 1'b0; mret = 1'b0; pc = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
  endtask

  logic [11:0] addr_tbl [14] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF11,
                                 12'hF12, 12'hB00, 12'hB80, 12'hC00, 12'hC80, 12'h7C0,
                                 12'h301, 12'h344};

  initial begin
    do_reset();
    // reset state
    peek("rst_mstatus", 12'h300, 32'h0000_1800);
    peek("rst_mepc", 12'h341, 32'h0);
    peek("rst_mcause", 12'h342, 32'h0);
    peek("rst_mscratch", 12'h340, 32'h0);
    peek("rst_mvendorid", 12'hF11, 32'h7973_7978);
    chk("rst_trap_valid", 32'(trap_valid), 32'h0);

    // mtvec write then ECALL on the next edge
    step(1, 1, 12'h305, 32'h8000_0103, 0, 0, 32'h0);
    step(1, 0, 12'h300, 32'h0, 1, 0, 32'h8000_0040);
    chk("ecall_valid", 32'(trap_valid), 32'h1);
    chk("ecall_pc", trap_pc, 32'h8000_0100);
    peek("ecall_mepc", 12'h341, 32'h8000_0040);
    peek("ecall_mcause", 12'h342, 32'd11);
    peek("ecall_mstatus", 12'h300, 32'h0000_1800);

    // ECALL then MRET round trip with MIE set
    step(1, 1, 12'h300, 32'h0000_0088, 0, 0, 32'h0);
    step(1, 0, 12'h300, 32'h0, 1, 0, 32'h8000_0200);
    peek("ecall2_mstatus", 12'h300, 32'h0000_1880);
    step(1, 0, 12'h300, 32'h0, 0, 1, 32'h8000_0300);
    chk("mret_pc", trap_pc, 32'h8000_0200);
    peek("mret_mstatus", 12'h300, 32'h0000_1888);
    step(0, 0, 12'h300, 32'h0, 0, 0, 32'h0);
    chk("mret_pulse_len", 32'(trap_valid), 32'h0);

    // ECALL swallows a simultaneous write; unimplemented address
    step(1, 1, 12'h340, 32'hDEAD_BEEF, 1, 0, 32'h8000_0400);
    peek("ecall_drop_wr", 12'h340, 32'h0);
    peek("illegal_data", 12'h7C0, 32'h0);
    chk("illegal_flag", 32'(csr_illegal), 32'h1);

`ifdef YSYX_25030093_CSR_MCYCLE_EN
    step(1, 1, 12'hB00, 32'hFFFF_FFFF, 0, 0, 32'h0);
    step(1, 1, 12'hB80, 32'h0, 0, 0, 32'h0);
    step(0, 1, 12'hB80, 32'h5, 0, 0, 32'h0);
    peek("mcycleh_carry", 12'hB80, 32'h1);
    peek("mcycle_wrap", 12'hC00, 32'h0);
`else
    peek("no_mcycle_data", 12'hB00, 32'h0);
    chk("no_mcycle_illegal", 32'(csr_illegal), 32'h1);
`endif

    // asynchronous reset during a redirect pulse
    step(1, 0, 12'h300, 32'h0, 1, 0, 32'h8000_0500);
    chk("pre_rst_valid", 32'(trap_valid), 32'h1);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(trap_valid), 32'h0);
    do_reset();
    peek("post_rst_mepc", 12'h341, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] rp;
      rp = $urandom;
      step(($urandom % 4) != 0, $urandom % 2, addr_tbl[$urandom % 14], $urandom,
           ($urandom % 8) == 0, ($urandom % 8) == 0, {rp[31:2], 2'b00});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
